// File: rtl/ddr_rom_writer.sv
// Packs 16-bit ROM-load words into one 64-bit line and writes full or flushed lines to a DDR3 port.
// Latency: a word is acked 1 edge after its request toggle unless the open line must be written out first.
// Backpressure: requests wait unacked while a line write is stalled by DDRAM_BUSY; a write holds WE/ADDR/DIN/BE until BUSY is low.
//
// Ports:
//   clk_sys, reset_n          - single clock, async active-low reset
//   wraddr, din, we_req/ack   - toggle-handshake word write (byte address, bit 0 ignored)
//   flush                     - one-cycle pulse to write out a partially filled line
//   DDRAM_*                   - DDR3 write port, single-beat bursts
//   busy                      - request pending, line buffer occupied or write in progress
module ddr_rom_writer #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic        flush,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] tag_q, tag_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  be_q, be_d;
  logic        ack_q, ack_d;
  logic        flush_pend_q, flush_pend_d;

  logic        req_pend;
  logic [21:0] req_line;
  logic [1:0]  req_lane;
  logic        line_hit;
  logic        unused_lsb;

  assign req_pend   = (we_req != ack_q);
  assign req_line   = wraddr[24:3];
  assign req_lane   = wraddr[2:1];
  // An empty buffer accepts any line; otherwise only words of the open line.
  assign line_hit   = (be_q == 8'h00) || (tag_q == req_line);
  assign unused_lsb = wraddr[0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      data_q       <= '0;
      be_q         <= '0;
      ack_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      be_q         <= be_d;
      ack_q        <= ack_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    data_d       = data_q;
    be_d         = be_q;
    ack_d        = ack_q;
    flush_pend_d = flush_pend_q | flush;

    case (state_q)
      IDLE: begin
        if (req_pend) begin
          if (line_hit) begin
            for (int k = 0; k < 4; k++) begin
              if (req_lane == k[1:0]) begin
                data_d[16*k +: 16] = din;
                be_d[2*k +: 2]     = 2'b11;
              end
            end
            tag_d = req_line;
            ack_d = we_req;
            // Lane 3 closes the line: start the write on the capture edge.
            if (req_lane == 2'd3) begin
              state_d = WRITE;
            end
          end else begin
            // Different line: write the open one out, capture afterwards.
            state_d = WRITE;
          end
        end else if (flush_pend_q) begin
          if (be_q != 8'h00) begin
            state_d = WRITE;
          end else begin
            // Nothing to flush; keep only a pulse arriving right now.
            flush_pend_d = flush;
          end
        end
      end

      WRITE: begin
        if (!DDRAM_BUSY) begin
          be_d         = 8'h00;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign we_ack         = ack_q;
  assign DDRAM_WE       = (state_q == WRITE);
  assign DDRAM_ADDR     = BASE_ADDR + {7'd0, tag_q};
  assign DDRAM_DIN      = data_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign busy           = req_pend || (be_q != 8'h00) || (state_q == WRITE);

endmodule

// File: tb/tb_ddr_rom_writer.sv
// Bench for ddr_rom_writer: line-buffer reference model feeds an expected-write queue,
// a monitor pops and compares every completed DDR write; acks are checked by the driver.
// Random and directed word streams, flushes, BUSY stalls and a mid-write reset.
module tb_ddr_rom_writer;

  localparam logic [28:0] BASE = 29'h0600000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic        flush;
  logic        DDRAM_BUSY;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  ddr_rom_writer #(.BASE_ADDR(BASE)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .wraddr         (wraddr),
    .din            (din),
    .we_req         (we_req),
    .we_ack         (we_ack),
    .flush          (flush),
    .DDRAM_BUSY     (DDRAM_BUSY),
    .DDRAM_ADDR     (DDRAM_ADDR),
    .DDRAM_DIN      (DDRAM_DIN),
    .DDRAM_BE       (DDRAM_BE),
    .DDRAM_WE       (DDRAM_WE),
    .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
    .busy           (busy)
  );

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] dat;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  we_cycles = 0;
  bit  busy_rand = 0;

  // Reference model: the open line as a tag plus per-word contents/enables.
  logic [21:0] m_tag = '0;
  logic [63:0] m_dat = '0;
  logic [7:0]  m_be  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_emit();
    wr_t w;
    if (m_be != 8'h00) begin
      w.addr = BASE + 29'(m_tag);
      w.dat  = m_dat;
      w.be   = m_be;
      exp_q.push_back(w);
      m_be = 8'h00;
    end
  endfunction

  task automatic monitor();
    wr_t   prev;
    wr_t   e;
    logic  prev_we = 1'b0;
    logic [63:0] mask;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_we = 1'b0;
      end else begin
        chk("burstcnt", DDRAM_BURSTCNT, 64'd1);
        if (DDRAM_WE) begin
          we_cycles++;
          if (prev_we) begin
            chk("hold_addr", DDRAM_ADDR, prev.addr);
            chk("hold_din", DDRAM_DIN, prev.dat);
            chk("hold_be", DDRAM_BE, prev.be);
          end
          prev.addr = DDRAM_ADDR;
          prev.dat  = DDRAM_DIN;
          prev.be   = DDRAM_BE;
          if (!DDRAM_BUSY) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_wr: addr %h be %h with no write expected (t=%0t)",
                       DDRAM_ADDR, DDRAM_BE, $time);
            end else begin
              e = exp_q.pop_front();
              mask = '0;
              for (int k = 0; k < 8; k++) if (e.be[k]) mask[8*k +: 8] = 8'hFF;
              chk("wr_addr", DDRAM_ADDR, e.addr);
              chk("wr_be", DDRAM_BE, e.be);
              chk("wr_din", DDRAM_DIN & mask, e.dat & mask);
            end
          end
        end
        prev_we = DDRAM_WE;
      end
    end
  endtask

  task automatic busy_gen();
    forever begin
      @(posedge clk_sys);
      #1;
      if (busy_rand) DDRAM_BUSY = ($urandom_range(0, 2) == 0);
    end
  endtask

  // Leaves the caller 1 ns after a rising edge with the DUT not writing.
  task automatic wait_idle();
    int t = 0;
    @(posedge clk_sys);
    #1;
    while (DDRAM_WE && t < 300) begin
      @(posedge clk_sys);
      #1;
      t++;
    end
    chk("idle_wait", DDRAM_WE, 0);
  endtask

  task automatic do_req(input logic [24:0] a, input logic [15:0] d, input bit with_flush);
    logic [21:0] line;
    logic [1:0]  lane;
    bit          need_wo;
    bit          lane3;
    int          base;
    int          t;
    wait_idle();
    line    = a[24:3];
    lane    = a[2:1];
    need_wo = (m_be != 8'h00) && (m_tag != line);
    base    = exp_q.size();
    if (need_wo) m_emit();
    m_tag = line;
    m_dat[16*lane +: 16] = d;
    m_be[2*lane +: 2]    = 2'b11;
    lane3 = (lane == 2'd3);
    if (lane3) m_emit();
    if (with_flush) m_emit();
    wraddr = a;
    din    = d;
    we_req = ~we_req;
    flush  = with_flush;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    if (!need_wo) begin
      chk("ack_1cyc", we_ack, we_req);
    end else begin
      t = 0;
      while (we_ack !== we_req && t < 300) begin
        @(posedge clk_sys);
        #1;
        t++;
      end
      chk("ack_after_wr", we_ack, we_req);
      chk("wr_before_ack", exp_q.size(), base + (lane3 ? 1 : 0));
    end
  endtask

  task automatic pulse_flush();
    wait_idle();
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int t = 0;
    pulse_flush();
    m_emit();
    repeat (2) @(posedge clk_sys);
    #1;
    while ((busy || DDRAM_WE) && t < 300) begin
      @(posedge clk_sys);
      #1;
      t++;
    end
    chk("flush_done", busy, 0);
  endtask

  task automatic wait_we_high();
    int t = 0;
    while (!DDRAM_WE && t < 20) begin
      @(posedge clk_sys);
      #1;
      t++;
    end
    chk("we_rise", DDRAM_WE, 1);
  endtask

  initial begin
    int w0;
    logic [21:0] line;
    logic [24:0] a;
    reset_n    = 1'b0;
    wraddr     = '0;
    din        = '0;
    we_req     = 1'b0;
    flush      = 1'b0;
    DDRAM_BUSY = 1'b0;
    fork
      monitor();
      busy_gen();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d compares done", n_cmp);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ack", we_ack, 0);
    chk("rst_we", DDRAM_WE, 0);
    chk("rst_be", DDRAM_BE, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Four words filling one line.
    do_req(25'h000, 16'h1111, 0);
    do_req(25'h002, 16'h2222, 0);
    do_req(25'h004, 16'h3333, 0);
    do_req(25'h006, 16'h4444, 0);
    do_flush();

    // Partial line displaced by a word of another line.
    do_req(25'h00A, 16'hBEEF, 0);
    do_req(25'h010, 16'h1234, 0);
    do_flush();

    // Lane overwrite within an open line.
    do_req(25'h022, 16'hAAAA, 0);
    do_req(25'h022, 16'h5555, 0);
    do_flush();

    // Flushed single-lane line held off by BUSY for 5 cycles.
    DDRAM_BUSY = 1'b1;
    do_req(25'h100, 16'hCAFE, 0);
    pulse_flush();
    m_emit();
    wait_we_high();
    w0 = we_cycles;
    repeat (5) @(posedge clk_sys);
    #1;
    DDRAM_BUSY = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("stall_we_cycles", we_cycles - w0, 6);
    chk("stall_busy_low", busy, 0);

    // Flush pulse together with a request into an empty buffer.
    do_req(25'h04A, 16'h7E7E, 1);
    do_flush();

    // Randomised word stream with random BUSY stalls.
    busy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        line = ($urandom_range(0, 9) < 8) ? 22'($urandom_range(0, 2)) : 22'($urandom);
        a = {line, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        do_req(a, 16'($urandom), (m_be == 8'h00) && ($urandom_range(0, 7) == 0));
      end else begin
        do_flush();
      end
    end
    do_flush();
    busy_rand = 0;
    @(posedge clk_sys);
    #1;
    DDRAM_BUSY = 1'b0;

    // Reset in the middle of a stalled write discards the line.
    DDRAM_BUSY = 1'b1;
    do_req(25'h200, 16'h5A5A, 0);
    pulse_flush();
    wait_we_high();
    @(posedge clk_sys);
    #3;
    reset_n = 1'b0;
    we_req  = 1'b0;
    #1;
    chk("arst_we", DDRAM_WE, 0);
    chk("arst_be", DDRAM_BE, 0);
    chk("arst_ack", we_ack, 0);
    m_be  = 8'h00;
    m_tag = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n    = 1'b1;
    DDRAM_BUSY = 1'b0;
    w0 = we_cycles;
    repeat (10) @(posedge clk_sys);
    #1;
    chk("no_wr_after_rst", we_cycles - w0, 0);
    chk("post_rst_busy", busy, 0);

    // Normal operation resumes after reset.
    do_req(25'h00E, 16'h9999, 0);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
